// File: rtl/btn_cond_pkg.sv
// Shared definitions for the button conditioner.
// Holds the per-button state encoding, default parameter values, width
// helpers used to size the tick/debounce/hold counters, and the button
// index map the device top uses to address btn_raw and the outputs.
package btn_cond_pkg;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_PEND   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_PEND = 2'd3
    } btn_state_e;

    localparam int unsigned DEF_N_BTN       = 8;
    localparam int unsigned DEF_CLK_HZ      = 100_000_000;
    localparam int unsigned DEF_DEBOUNCE_MS = 20;
    localparam int unsigned DEF_LONG_MS     = 1000;

    // Button index map used by the device top.
    localparam int unsigned BTN_ON      = 0;
    localparam int unsigned BTN_OFF     = 1;
    localparam int unsigned BTN_MANUAL  = 2;
    localparam int unsigned BTN_LEFT    = 3;
    localparam int unsigned BTN_RIGHT   = 4;
    localparam int unsigned BTN_FWD     = 5;
    localparam int unsigned BTN_BACK    = 6;
    localparam int unsigned BTN_BARRIER = 7;

    // sys_clk cycles per 1 ms tick; clocks below 1 kHz tick every cycle.
    function automatic int unsigned tick_div(input int unsigned clk_hz);
        return (clk_hz < 1000) ? 1 : clk_hz / 1000;
    endfunction

    // Bits needed to hold values 0..n_vals-1, never less than 1.
    function automatic int unsigned cnt_w(input int unsigned n_vals);
        return (n_vals <= 2) ? 1 : $clog2(n_vals);
    endfunction

    localparam int unsigned DEF_TICK_DIV = tick_div(DEF_CLK_HZ);

endpackage

// File: rtl/btn_cond_cell.sv
// One button's debounce / long-press state machine.
// Ports:
//   clk_i, rst_ni    clock, asynchronous active-low reset
//   s_i              synchronised button level (1 = pressed)
//   tick_i           1 ms tick, one cycle wide
//   level_o          debounced level
//   press_o          1-cycle pulse on an accepted press
//   release_o        1-cycle pulse on an accepted release
//   long_o           1-cycle pulse once a press has been held LONG_MS ticks
module btn_cond_cell
    import btn_cond_pkg::*;
#(
    parameter int unsigned DEBOUNCE_MS = DEF_DEBOUNCE_MS,
    parameter int unsigned LONG_MS     = DEF_LONG_MS
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic s_i,
    input  logic tick_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic long_o
);

    localparam int unsigned DB_W   = cnt_w(DEBOUNCE_MS + 1);
    localparam int unsigned HOLD_W = cnt_w(LONG_MS + 1);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_MS - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_MS);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_MS - 1);

    btn_state_e        state_q, state_d;
    logic [DB_W-1:0]   db_q, db_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              level_q, level_d;
    logic              press_q, press_d;
    logic              release_q, release_d;
    logic              long_q, long_d;

    // State register and registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= RELEASED;
            db_q      <= '0;
            hold_q    <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            db_q      <= db_d;
            hold_q    <= hold_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
        end
    end

    // Next-state, counters and pulses.
    always_comb begin
        state_d   = state_q;
        db_d      = db_q;
        hold_d    = hold_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;

        // Hold time accrues through release bounces; saturation keeps long one-shot.
        if ((state_q == PRESSED || state_q == RELEASE_PEND) && tick_i) begin
            if (hold_q != HOLD_MAX) begin
                hold_d = hold_q + HOLD_W'(1);
            end
            long_d = (hold_q == HOLD_LAST);
        end

        unique case (state_q)
            RELEASED: begin
                if (s_i) begin
                    state_d = PRESS_PEND;
                    db_d    = '0;
                end
            end
            PRESS_PEND: begin
                // A bounce wins over a coincident tick.
                if (!s_i) begin
                    state_d = RELEASED;
                    db_d    = '0;
                end else if (tick_i) begin
                    if (db_q == DB_LAST) begin
                        state_d = PRESSED;
                        db_d    = '0;
                        hold_d  = '0;
                        level_d = 1'b1;
                        press_d = 1'b1;
                    end else begin
                        db_d = db_q + DB_W'(1);
                    end
                end
            end
            PRESSED: begin
                if (!s_i) begin
                    state_d = RELEASE_PEND;
                    db_d    = '0;
                end
            end
            RELEASE_PEND: begin
                if (s_i) begin
                    state_d = PRESSED;
                    db_d    = '0;
                end else if (tick_i) begin
                    if (db_q == DB_LAST) begin
                        state_d   = RELEASED;
                        db_d      = '0;
                        hold_d    = '0;
                        level_d   = 1'b0;
                        release_d = 1'b1;
                        long_d    = 1'b0;
                    end else begin
                        db_d = db_q + DB_W'(1);
                    end
                end
            end
            default: begin
                state_d = RELEASED;
            end
        endcase
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign long_o    = long_q;

endmodule

// File: rtl/btn_conditioner.sv
// Button conditioner: synchronises, debounces and pulse-encodes N_BTN raw
// board buttons on sys_clk using an internal 1 ms tick.
// Build option: BTN_COND_SYNC_EN defined inserts a 2-flop synchroniser on
// btn_raw; undefined feeds btn_raw straight to the cells (btn_raw must then
// be synchronous to sys_clk).
// Ports:
//   sys_clk, rst_n   clock, asynchronous active-low reset
//   btn_raw          raw button inputs (1 = pressed)
//   btn_level        debounced levels
//   btn_press        1-cycle accepted-press pulses
//   btn_release      1-cycle accepted-release pulses
//   btn_long         1-cycle long-press pulses
//   ms_tick          1-cycle pulse every CLK_HZ/1000 cycles
module btn_conditioner
    import btn_cond_pkg::*;
#(
    parameter int unsigned N_BTN       = DEF_N_BTN,
    parameter int unsigned CLK_HZ      = DEF_CLK_HZ,
    parameter int unsigned DEBOUNCE_MS = DEF_DEBOUNCE_MS,
    parameter int unsigned LONG_MS     = DEF_LONG_MS
) (
    input  logic             sys_clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_long,
    output logic             ms_tick
);

    localparam int unsigned TICK_DIV = tick_div(CLK_HZ);
    localparam int unsigned TICK_W   = cnt_w(TICK_DIV);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic              ms_tick_q, ms_tick_d;
    logic [N_BTN-1:0]  btn_sync;

    // Free-running ms divider; the tick register mirrors tick_cnt == TICK_DIV-1.
    always_comb begin
        tick_cnt_d = (tick_cnt_q == TICK_LAST) ? '0 : tick_cnt_q + TICK_W'(1);
        ms_tick_d  = (tick_cnt_d == TICK_LAST);
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_q <= '0;
            ms_tick_q  <= 1'b0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            ms_tick_q  <= ms_tick_d;
        end
    end

    assign ms_tick = ms_tick_q;

`ifdef BTN_COND_SYNC_EN
    logic [N_BTN-1:0] sync1_q, sync2_q;

    // Two-flop synchroniser for the asynchronous button pins.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

    assign btn_sync = sync2_q;
`else
    assign btn_sync = btn_raw;
`endif

    for (genvar i = 0; i < int'(N_BTN); i++) begin : g_cell
        btn_cond_cell #(
            .DEBOUNCE_MS (DEBOUNCE_MS),
            .LONG_MS     (LONG_MS)
        ) u_cell (
            .clk_i     (sys_clk),
            .rst_ni    (rst_n),
            .s_i       (btn_sync[i]),
            .tick_i    (ms_tick_q),
            .level_o   (btn_level[i]),
            .press_o   (btn_press[i]),
            .release_o (btn_release[i]),
            .long_o    (btn_long[i])
        );
    end

endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
- Upstream conditioning stage for the device top's raw board buttons: power on/off, manual mode, turn, move and barrier.
- Synchronises and debounces each button.
- Emits clean levels, one-cycle press/release pulses and a one-shot long-press pulse.
- Replaces ad-hoc slow-clock button sampling; everything runs on sys_clk with an internal 1 ms tick, so the top's state machine can consume pulses directly in the sys_clk domain.

Parameters:
- N_BTN, 8, number of buttons conditioned.
- CLK_HZ, 100000000, sys_clk frequency in Hz.
- DEBOUNCE_MS, 20, number of ms ticks an input must be stable before its level is accepted (>=1).
- LONG_MS, 1000, number of ms ticks a debounced press must be held to fire long_pulse (>=1).

Ports:
- sys_clk  input  1  system clock. One clock domain.
- rst_n  input  1  reset, asynchronous, active-low.
- btn_raw  input  N_BTN  raw, asynchronous button inputs (1 = pressed).
- btn_level  output  N_BTN  debounced level.
- btn_press  output  N_BTN  1-cycle pulse on an accepted 0->1 transition.
- btn_release  output  N_BTN  1-cycle pulse on an accepted 1->0 transition.
- btn_long  output  N_BTN  1-cycle pulse when a press has been held LONG_MS ticks.
- ms_tick  output  1  1-cycle pulse every CLK_HZ/1000 cycles; exported for other blocks.

Behaviour:
- Reset (rst_n low, asynchronous): all outputs 0; synchronisers, tick counter and all per-button counters 0; every button in state RELEASED.
- Tick generation:
  - TICK_DIV = CLK_HZ/1000; tick_cnt counts 0..TICK_DIV-1 and wraps.
  - ms_tick is high in the cycle where tick_cnt == TICK_DIV-1.
  - Counter width is $clog2(TICK_DIV).
- Synchroniser: each btn_raw bit passes through 2 flops; s[i] is the synchronised value. Sync latency is 2 cycles.
- Per-button FSM (states RELEASED, PRESS_PEND, PRESSED, RELEASE_PEND) with a debounce counter db_cnt (width $clog2(DEBOUNCE_MS+1)):
  - RELEASED: s=1 -> PRESS_PEND, db_cnt=0.
  - PRESS_PEND:
    - s=0 -> RELEASED (bounce; db_cnt=0).
    - Otherwise db_cnt increments on each ms_tick.
    - When db_cnt reaches DEBOUNCE_MS -> PRESSED: btn_level=1, btn_press pulses the next cycle, hold_cnt=0.
  - PRESSED: s=0 -> RELEASE_PEND, db_cnt=0.
  - RELEASE_PEND:
    - s=1 -> PRESSED (bounce; hold_cnt keeps counting).
    - Otherwise db_cnt increments on ms_tick.
    - At DEBOUNCE_MS -> RELEASED: btn_level=0, btn_release pulses.
- Acceptance latency from a stable change at s: between (DEBOUNCE_MS-1)*TICK_DIV+1 and DEBOUNCE_MS*TICK_DIV cycles, plus 1 register cycle.
- Long press:
  - hold_cnt (width $clog2(LONG_MS+1)) increments on ms_tick while in PRESSED or RELEASE_PEND.
  - It saturates at LONG_MS.
  - btn_long pulses exactly once, in the cycle after hold_cnt reaches LONG_MS.
  - It never re-fires until the button returns to RELEASED, which clears hold_cnt.
- Pulses are registered and high for exactly 1 cycle. press, release and long are mutually exclusive per button per cycle.
- Buttons are fully independent. Simultaneous transitions on several buttons give simultaneous pulses.
- ms_tick coinciding with a bounce: the bounce wins, db_cnt clears and the tick is ignored for that button.
- Reset mid-press: all state is cleared and no pulse is emitted. If the button is still held after reset, it is re-debounced and then produces btn_press.

Optional Feature:
- Macro BTN_COND_SYNC_EN.
- Defined: 2-flop synchroniser on btn_raw, as above.
- Undefined: s = btn_raw directly. For simulation only: 2 cycles less latency, and the bench must drive btn_raw synchronous to sys_clk. All other behaviour is identical.

Decomposition:
- Shared package btn_cond_pkg holds:
  - state encoding enum (RELEASED=2'd0, PRESS_PEND=2'd1, PRESSED=2'd2, RELEASE_PEND=2'd3);
  - default-constant helpers for the TICK_DIV computation.
  - It also provides the button index constants used by the device top: BTN_ON=0, BTN_OFF=1, BTN_MANUAL=2, BTN_LEFT=3, BTN_RIGHT=4, BTN_FWD=5, BTN_BACK=6, BTN_BARRIER=7.
- Sub-module btn_cond_cell: one button's FSM plus its db_cnt/hold_cnt, fed s and ms_tick. The top generates N_BTN instances, the shared tick counter and the synchronisers.

Test Plan (CLK_HZ=10000 -> TICK_DIV=10, DEBOUNCE_MS=3, LONG_MS=10, N_BTN=8, sync enabled):
- Reset: rst_n low for 5 cycles with btn_raw=8'hFF -> all outputs 0. Release reset -> ms_tick first high in cycle 9 after release, then every 10 cycles.
- Clean press of bit 0, held 200 cycles:
  - btn_press[0] is a single 1-cycle pulse 23..33 cycles after the edge, and btn_level[0]=1 from the same cycle.
  - btn_long[0] pulses exactly once, about 100 cycles after btn_press.
- Bounce: bit 3 toggles every 7 cycles for 60 cycles, then stays 0 -> no pulses and btn_level[3] stays 0.
- Release glitch: bit 5 held, then one 12-cycle low glitch at hold time 40 ticks -> no btn_release. btn_long still fires once at 10 ticks and is not repeated.
- Simultaneous: bits 1 and 6 pressed in the same cycle -> btn_press[1] and btn_press[6] pulse in the same cycle. Releasing only bit 1 -> only btn_release[1].
- Reset mid-press: assert rst_n low while bit 2 is PRESSED with hold_cnt=5 -> outputs clear immediately with no release pulse. Button still held -> btn_press[2] again 23..33 cycles after reset release.
